// File: rtl/encoder_pkg.sv
// rtl/encoder_pkg.sv - quadrature state encodings, decode result type and decode helper for encoder_qep
package encoder_pkg;

   localparam int ERR_CNT_W = 8;

   localparam logic [1:0] ST_00 = 2'b00;
   localparam logic [1:0] ST_01 = 2'b01;
   localparam logic [1:0] ST_10 = 2'b10;
   localparam logic [1:0] ST_11 = 2'b11;

   typedef enum logic [1:0] {NONE, INC, DEC, ILLEGAL} decode_t;

   // Position of an {A,B} state along the forward cycle 00->10->11->01.
   function automatic logic [1:0] phase(input logic [1:0] ab);
      case (ab)
         ST_00:   phase = 2'd0;
         ST_10:   phase = 2'd1;
         ST_11:   phase = 2'd2;
         default: phase = 2'd3;
      endcase
   endfunction

   function automatic decode_t decode(input logic [1:0] prev, input logic [1:0] cur);
      logic [1:0] d;
      d = phase(cur) - phase(prev);
      case (d)
         2'd0:    decode = NONE;
         2'd1:    decode = INC;
         2'd3:    decode = DEC;
         default: decode = ILLEGAL;
      endcase
   endfunction

endpackage

// File: rtl/encoder_filter.sv
// rtl/encoder_filter.sv - two-flop pin synchroniser followed by a stability filter
module encoder_filter #(
   parameter int FILT_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [FILT_W-1:0] filt_len,
   input  logic              in,
   input  logic              arm_load,
   output logic              out,
   output logic              sync
);

   localparam logic [FILT_W-1:0] ONE = FILT_W'(1);

   logic              ff1;
   logic              ff2;
   logic [FILT_W-1:0] cnt;

   assign sync = ff2;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ff1 <= 1'b0;
         ff2 <= 1'b0;
         out <= 1'b0;
         cnt <= '0;
      end else begin
         ff1 <= in;
         ff2 <= ff1;
         // Arming takes the synchronised pin as-is so no edge is seen at start-up.
         if (arm_load) begin
            out <= ff2;
            cnt <= '0;
         end else if (ff2 == out) begin
            cnt <= '0;
         end else if (cnt == filt_len) begin
            out <= ff2;
            cnt <= '0;
         end else begin
            cnt <= cnt + ONE;
         end
      end
   end

endmodule

// File: rtl/encoder_qep.sv
// rtl/encoder_qep.sv - x4 quadrature decoder with wrapping position and illegal-transition flags; index logic under QEP_INDEX_EN
module encoder_qep
   import encoder_pkg::*;
#(
   parameter int CNT_W  = 32,
   parameter int FILT_W = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 A,
   input  logic                 B,
   input  logic                 Z,
   input  logic [FILT_W-1:0]    filt_len,
   input  logic [CNT_W-1:0]     ppr,
   input  logic                 clr,
   input  logic                 idx_home,
   output logic [CNT_W-1:0]     steps,
   output logic [CNT_W-1:0]     position,
   output logic                 dir,
   output logic                 err,
   output logic [ERR_CNT_W-1:0] err_cnt,
   output logic                 index_seen,
   output logic [CNT_W-1:0]     index_pos
);

   localparam logic [CNT_W-1:0]     ONE   = CNT_W'(1);
   localparam logic [ERR_CNT_W-1:0] E_ONE = ERR_CNT_W'(1);

   logic       armed;
   logic [1:0] arm_cnt;
   logic       arm_load;
   logic       a_f, b_f, a_sync, b_sync;
   logic [1:0] ab_q;
   decode_t    res;
   logic       home;

   logic [CNT_W-1:0] steps_nx, pos_nx, ppr_m1;
   logic             dir_nx;

   encoder_filter #(.FILT_W(FILT_W)) u_filt_a (
      .clk(clk), .rst_n(rst_n), .filt_len(filt_len), .in(A),
      .arm_load(arm_load), .out(a_f), .sync(a_sync)
   );

   encoder_filter #(.FILT_W(FILT_W)) u_filt_b (
      .clk(clk), .rst_n(rst_n), .filt_len(filt_len), .in(B),
      .arm_load(arm_load), .out(b_f), .sync(b_sync)
   );

   // Third edge out of reset: ff2 then holds a genuine pin sample.
   assign arm_load = !armed && (arm_cnt == 2'd2);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         arm_cnt <= 2'd0;
         armed   <= 1'b0;
      end else if (!armed) begin
         arm_cnt <= arm_cnt + 2'd1;
         if (arm_load)
            armed <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n)
         ab_q <= ST_00;
      else if (arm_load)
         ab_q <= {a_sync, b_sync};
      else if (armed)
         ab_q <= {a_f, b_f};
   end

   assign res    = armed ? decode(ab_q, {a_f, b_f}) : NONE;
   assign ppr_m1 = ppr - ONE;

   always_comb begin
      steps_nx = steps;
      pos_nx   = position;
      dir_nx   = dir;
      case (res)
         INC: begin
            steps_nx = steps + ONE;
            dir_nx   = 1'b1;
            if (ppr == '0)
               pos_nx = position + ONE;
            else if (position >= ppr_m1)
               pos_nx = '0;
            else
               pos_nx = position + ONE;
         end
         DEC: begin
            steps_nx = steps - ONE;
            dir_nx   = 1'b0;
            // Out-of-range positions (ppr lowered at run time) snap to the top of the revolution.
            if (ppr == '0)
               pos_nx = position - ONE;
            else if (position == '0 || position >= ppr)
               pos_nx = ppr_m1;
            else
               pos_nx = position - ONE;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n || clr) begin
         steps    <= '0;
         position <= '0;
         dir      <= 1'b0;
         err      <= 1'b0;
         err_cnt  <= '0;
      end else begin
         steps    <= steps_nx;
         position <= home ? '0 : pos_nx;
         dir      <= dir_nx;
         if (res == ILLEGAL) begin
            err <= 1'b1;
            if (err_cnt != '1)
               err_cnt <= err_cnt + E_ONE;
         end
      end
   end

`ifdef QEP_INDEX_EN
   logic z_f, z_sync, z_q, z_rise;

   encoder_filter #(.FILT_W(FILT_W)) u_filt_z (
      .clk(clk), .rst_n(rst_n), .filt_len(filt_len), .in(Z),
      .arm_load(arm_load), .out(z_f), .sync(z_sync)
   );

   always_ff @(posedge clk) begin
      if (!rst_n)
         z_q <= 1'b0;
      else if (arm_load)
         z_q <= z_sync;
      else if (armed)
         z_q <= z_f;
   end

   assign z_rise = armed && z_f && !z_q;
   assign home   = z_rise && idx_home;

   // index_pos captures the steps value being written this edge, so a coincident count is included.
   always_ff @(posedge clk) begin
      if (!rst_n || clr) begin
         index_seen <= 1'b0;
         index_pos  <= '0;
      end else if (z_rise) begin
         index_seen <= 1'b1;
         index_pos  <= steps_nx;
      end
   end
`else
   wire unused_index_pins = &{1'b0, Z, idx_home};

   assign home       = 1'b0;
   assign index_seen = 1'b0;
   assign index_pos  = '0;
`endif

endmodule
